mem_access_master: RTL and testbench
====================================

# mem_access_master

Initiator-side sequencer for the instruction/data memory system: accepts load/store requests from the core over a valid/ready handshake and drives the memory system's write-enable, address and write-data pins, capturing its read data. Converts byte/halfword accesses into word-aligned memory cycles, performs read-modify-write for sub-word stores, and sign/zero-extends loads. It also rejects misaligned accesses and stores into the ROM region below `ROM_LIMIT`.

## Interface
- `DATA_WIDTH`, 32, data and address width.
- `ROM_LIMIT`, 32'h10000000, addresses below this are ROM (read-only).

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  block can accept a request.
- `req_write_i`  in  1  1 = store, 0 = load.
- `req_size_i`  in  2  00 byte, 01 halfword, 10 word; 11 is treated as an error.
- `req_unsigned_i`  in  1  zero-extend loads when 1, sign-extend when 0.
- `req_addr_i`  in  32  byte address.
- `req_wdata_i`  in  32  store data, right-aligned.
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rsp_rdata_o`  out  32  extended load data; 0 for stores and errors.
- `rsp_error_o`  out  1  access rejected; qualified by `rsp_valid_o`.
- `mem_write_enable_o`  out  1  to the memory system's write enable.
- `mem_address_o`  out  32  word-aligned address; bits [1:0] are always 0.
- `mem_write_data_o`  out  32  full word to write.
- `mem_read_data_i`  in  32  combinational read data from the memory system for `mem_address_o`.

## Operation
- The memory system returns read data combinationally in the same cycle and writes on the `clk` edge while write enable is high.
- A request is accepted on an edge where `req_valid_i && req_ready_o`.
  - All request fields are latched at that edge.
  - `req_ready_o` = (state == IDLE).
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE → RESP with error, with no memory cycle, when any of these holds:
  - halfword with `addr[0]` = 1;
  - word with `addr[1:0]` != 0;
  - size 11;
  - store with `addr < ROM_LIMIT`.
- IDLE → READ for a load, or for a sub-word store.
- IDLE → WRITE for a word store.
- READ:
  - Drive the aligned address and register `mem_read_data_i`.
  - Next state is RESP for a load, WRITE for a sub-word store.
- WRITE:
  - `mem_write_enable_o` = 1 for exactly this cycle.
  - Write data is either `req_wdata` (word store) or the merged word: captured word with the addressed lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`, little-endian lanes, byte lane = `addr[1:0]`, half lane = `addr[1]`.
  - Next state is RESP.
- RESP:
  - `rsp_valid_o` = 1 for one cycle; there is no response backpressure.
  - Next state is IDLE.
- Load extraction: select the byte/half lane from the captured word, then extend to 32 bits per `req_unsigned`.
- `mem_write_enable_o` is high only in WRITE. `mem_address_o` holds the latched aligned address outside IDLE and is 0 in IDLE.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE; `req_ready_o` = 1;
  - `rsp_valid_o`, `rsp_error_o`, `mem_write_enable_o` = 0;
  - `rsp_rdata_o`, `mem_address_o`, `mem_write_data_o` = 0.
- Reset mid-operation aborts the operation. If reset asserts during WRITE, write enable drops at once, so the memory write on that edge is not guaranteed. No response is issued for the aborted request.
- Latency from the acceptance edge to `rsp_valid_o` high:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- A new request can be accepted in the cycle after RESP. Back-to-back throughput is one access per 3 cycles (4 cycles for a sub-word RMW).
- `req_valid_i` while not ready is ignored. The requester must hold the request until it is accepted.

## Configuration
- `MEM_ACCESS_MASTER_RMW_EN` defined: sub-word stores perform READ → WRITE RMW as above.
- Not defined:
  - Sub-word stores go IDLE → RESP with `rsp_error_o` = 1 and no memory cycle.
  - Word stores and all loads are unchanged.
  - The READ→WRITE path and merge logic are removed.

## Test plan
- Word load at 0x00000004, memory word 0x8BADF00D → `rsp_valid_o` 2 cycles after acceptance, `rsp_rdata_o` = 0x8BADF00D, error 0, write enable never high.
- Signed byte load at 0x10000003 with word 0x80FF1234 → `mem_address_o` = 0x10000000, `rsp_rdata_o` = 0xFFFFFF80. The same load unsigned → 0x00000080.
- Byte store 0xAB at 0x10000001, word 0x11223344 (RMW_EN defined) → exactly one write-enable cycle with data 0x1122AB44, response at cycle 3. With RMW_EN undefined → error response after 1 cycle and no write.
- Word store at 0x00000010 (ROM region) and halfword load at 0x10000001 → each gives an error response after 1 cycle, rdata 0, write enable never asserted.
- Assert `reset` during the WRITE cycle of a word store at 0x10000008 → write enable drops in the same cycle, `rsp_valid_o` never pulses, `req_ready_o` = 1 immediately.
- Hold `req_valid_i` high for three consecutive word loads → acceptances spaced 3 cycles apart, three single-cycle responses with the correct data in order.

Source files
------------

// File: rtl/mem_access_master_if.sv
// Core request/response and memory-pin bundle for mem_access_master.
// The master modport is the sequencer's view; slave is the core + memory side.
interface mem_access_master_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [1:0]            req_size_i;
  logic                  req_unsigned_i;
  logic [DATA_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_error_o;
  logic                  mem_write_enable_o;
  logic [DATA_WIDTH-1:0] mem_address_o;
  logic [DATA_WIDTH-1:0] mem_write_data_o;
  logic [DATA_WIDTH-1:0] mem_read_data_i;

  modport master (
    input  req_valid_i, req_write_i, req_size_i, req_unsigned_i,
    input  req_addr_i, req_wdata_i, mem_read_data_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
    output mem_write_enable_o, mem_address_o, mem_write_data_o
  );

  modport slave (
    output req_valid_i, req_write_i, req_size_i, req_unsigned_i,
    output req_addr_i, req_wdata_i, mem_read_data_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
    input  mem_write_enable_o, mem_address_o, mem_write_data_o
  );
endinterface

// File: rtl/mem_access_master.sv
// Load/store sequencer: word-aligned memory cycles, sub-word RMW stores, load extension.
// Define MEM_ACCESS_MASTER_RMW_EN to enable sub-word stores; otherwise they are rejected.
module mem_access_master #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ROM_LIMIT  = 32'h1000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_access_master_if.master  bus
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                state, state_nx;
  logic                  accept, reject;
  logic                  write_p0, uns_p0, err_p0;
  logic [1:0]            size_p0;
  logic [DATA_WIDTH-1:0] addr_p0, wdata_p0;
  logic [DATA_WIDTH-1:0] word_p1;
  logic [DATA_WIDTH-1:0] wr_word;

  function automatic logic [DATA_WIDTH-1:0] load_extend(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            size,
    input logic [1:0]            lane,
    input logic                  uns
  );
    logic signed [7:0]            sb;
    logic signed [15:0]           sh;
    logic signed [DATA_WIDTH-1:0] res;
    sb = word[{lane, 3'b000} +: 8];
    sh = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: if (uns) res = {{(DATA_WIDTH-8){1'b0}}, sb};
               else     res = sb;
      SZ_HALF: if (uns) res = {{(DATA_WIDTH-16){1'b0}}, sh};
               else     res = sh;
      default: res = word;
    endcase
    return res;
  endfunction

`ifdef MEM_ACCESS_MASTER_RMW_EN
  function automatic logic [DATA_WIDTH-1:0] store_merge(
    input logic [DATA_WIDTH-1:0] word,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [1:0]            size,
    input logic [1:0]            lane
  );
    logic [DATA_WIDTH-1:0] res;
    res = word;
    if (size == SZ_BYTE) res[{lane, 3'b000} +: 8]     = wdata[7:0];
    else                 res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
    return res;
  endfunction

  assign wr_word = (size_p0 == SZ_WORD) ? wdata_p0
                 : store_merge(word_p1, wdata_p0, size_p0, addr_p0[1:0]);
`else
  assign wr_word = wdata_p0;
`endif

  assign accept = bus.req_valid_i && (state == IDLE);

  always_comb begin
    reject = (bus.req_size_i == 2'b11)
          || (bus.req_size_i == SZ_HALF && bus.req_addr_i[0])
          || (bus.req_size_i == SZ_WORD && bus.req_addr_i[1:0] != 2'b00)
          || (bus.req_write_i && bus.req_addr_i < ROM_LIMIT);
`ifndef MEM_ACCESS_MASTER_RMW_EN
    if (bus.req_write_i && bus.req_size_i != SZ_WORD) reject = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // p0: request latched at acceptance; p1: memory word captured in READ
  always_ff @(posedge clk) begin
    if (accept) begin
      write_p0 <= bus.req_write_i;
      size_p0  <= bus.req_size_i;
      uns_p0   <= bus.req_unsigned_i;
      addr_p0  <= bus.req_addr_i;
      wdata_p0 <= bus.req_wdata_i;
      err_p0   <= reject;
    end
    if (state == READ) word_p1 <= bus.mem_read_data_i;
  end

  always_comb begin
    state_nx               = state;
    bus.req_ready_o        = 1'b0;
    bus.rsp_valid_o        = 1'b0;
    bus.rsp_error_o        = 1'b0;
    bus.rsp_rdata_o        = '0;
    bus.mem_write_enable_o = 1'b0;
    bus.mem_address_o      = {addr_p0[DATA_WIDTH-1:2], 2'b00};
    bus.mem_write_data_o   = '0;
    unique case (state)
      IDLE: begin
        bus.req_ready_o   = 1'b1;
        bus.mem_address_o = '0;
        if (accept) begin
          if (reject)                                             state_nx = RESP;
          else if (bus.req_write_i && bus.req_size_i == SZ_WORD)  state_nx = WRITE;
          else                                                    state_nx = READ;
        end
      end
      READ: begin
`ifdef MEM_ACCESS_MASTER_RMW_EN
        state_nx = write_p0 ? WRITE : RESP;
`else
        state_nx = RESP;
`endif
      end
      WRITE: begin
        bus.mem_write_enable_o = 1'b1;
        bus.mem_write_data_o   = wr_word;
        state_nx               = RESP;
      end
      RESP: begin
        bus.rsp_valid_o = 1'b1;
        bus.rsp_error_o = err_p0;
        if (!err_p0 && !write_p0)
          bus.rsp_rdata_o = load_extend(word_p1, size_p0, addr_p0[1:0], uns_p0);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_master.sv
// Randomized bench for mem_access_master with a transaction-level reference model
// and directed literal cases; works with or without MEM_ACCESS_MASTER_RMW_EN.
module tb_mem_access_master;

  localparam logic [31:0] ROM_LIMIT = 32'h1000_0000;
`ifdef MEM_ACCESS_MASTER_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic clk;
  logic reset;

  mem_access_master_if #(.DATA_WIDTH(32)) bus();

  mem_access_master #(.DATA_WIDTH(32), .ROM_LIMIT(ROM_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory system: 16 words aliased on address bits [5:2], combinational read.
  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic        pl_we;
  logic [3:0]  pl_idx;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) mem[pl_idx] <= pl_data;
    else if (bus.mem_write_enable_o) mem[bus.mem_address_o[5:2]] <= bus.mem_write_data_o;
  end
  assign bus.mem_read_data_i = mem[bus.mem_address_o[5:2]];

  int          total, bad;
  int          we_cnt;
  logic [31:0] last_wd;
  logic [31:0] rsp_log[$];

  bit          m_busy, m_err, m_w;
  int          m_k, m_lat;
  logic [31:0] m_addr, m_rd, m_nw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: outcome of one access from its fields and the current memory word.
  function automatic void predict(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] word, output bit err, output int lat,
                                  output logic [31:0] rdata, output logic [31:0] nword);
    int          sh;
    logic [31:0] mask;
    err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0)
       || (w && a < ROM_LIMIT) || (!RMW && w && sz != 2'd2);
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    sh   = (sz == 2'd0) ? int'(a % 4) * 8 : (sz == 2'd1) ? (int'(a % 4) / 2) * 16 : 0;
    lat  = err ? 1 : (w && sz != 2'd2) ? 3 : 2;
    rdata = (word >> sh) & mask;
    if (!u && sz != 2'd2 && (rdata & ((mask >> 1) + 32'd1)) != 0) rdata = rdata | ~mask;
    if (err || w) rdata = 32'd0;
    nword = (sz == 2'd2) ? wd : ((word & ~(mask << sh)) | ((wd & mask) << sh));
  endfunction

  task automatic model_step();
    bit exp_rsp, exp_we;
    if (pl_we) ref_mem[pl_idx] = pl_data;
    if (bus.mem_write_enable_o === 1'b1) begin
      we_cnt++;
      last_wd = bus.mem_write_data_o;
    end
    if (bus.rsp_valid_o === 1'b1) rsp_log.push_back(bus.rsp_rdata_o);
    if (reset) begin
      m_busy = 1'b0;
      chk("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
      chk("rst_rsp_error", {31'd0, bus.rsp_error_o}, 32'd0);
      chk("rst_we", {31'd0, bus.mem_write_enable_o}, 32'd0);
      chk("rst_rdata", bus.rsp_rdata_o, 32'd0);
      chk("rst_addr", bus.mem_address_o, 32'd0);
      chk("rst_wdata", bus.mem_write_data_o, 32'd0);
    end else begin
      exp_rsp = m_busy && m_k == m_lat;
      exp_we  = m_busy && m_w && !m_err && m_k == m_lat - 1;
      chk("ready", {31'd0, bus.req_ready_o}, {31'd0, !m_busy});
      chk("rsp_valid", {31'd0, bus.rsp_valid_o}, {31'd0, exp_rsp});
      chk("rsp_error", {31'd0, bus.rsp_error_o}, {31'd0, exp_rsp && m_err});
      chk("rsp_rdata", bus.rsp_rdata_o, exp_rsp ? m_rd : 32'd0);
      chk("mem_we", {31'd0, bus.mem_write_enable_o}, {31'd0, exp_we});
      chk("mem_addr", bus.mem_address_o, m_busy ? (m_addr & ~32'd3) : 32'd0);
      chk("mem_wdata", bus.mem_write_data_o, exp_we ? m_nw : 32'd0);
      if (exp_we) ref_mem[m_addr[5:2]] = m_nw;
      if (m_busy) begin
        if (m_k == m_lat) m_busy = 1'b0;
        else m_k++;
      end else if (bus.req_valid_i) begin
        m_busy = 1'b1;
        m_k    = 1;
        m_w    = bus.req_write_i;
        m_addr = bus.req_addr_i;
        predict(bus.req_write_i, bus.req_size_i, bus.req_unsigned_i, bus.req_addr_i,
                bus.req_wdata_i, ref_mem[bus.req_addr_i[5:2]], m_err, m_lat, m_rd, m_nw);
      end
    end
  endtask

  task automatic set_word(input logic [3:0] idx, input logic [31:0] data);
    pl_we = 1'b1; pl_idx = idx; pl_data = data;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    bit rdy, ok;
    bus.req_valid_i = 1'b1; bus.req_write_i = w; bus.req_size_i = sz;
    bus.req_unsigned_i = u; bus.req_addr_i = a; bus.req_wdata_i = wd;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rdy = bus.req_ready_o;
      @(posedge clk); #1;
      if (rdy) begin ok = 1'b1; break; end
    end
    chk("accept_within_bound", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er);
    lat = -1; rd = 'x; er = 'x;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid_o === 1'b1) begin
        lat = n; rd = bus.rsp_rdata_o; er = bus.rsp_error_o;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  int          lat, w0;
  logic [31:0] rd;
  logic        er;
  longint      t1, t2, t3;

  initial begin
    total = 0; bad = 0; we_cnt = 0; last_wd = '0; m_busy = 1'b0;
    pl_we = 1'b0; pl_idx = '0; pl_data = '0;
    bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_size_i = 2'd0;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    reset = 1'b1;
    fork
      forever begin
        @(negedge clk);
        model_step();
      end
    join_none
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 16; i++) set_word(4'(i), $urandom);

    // Word load
    set_word(4'd1, 32'h8BAD_F00D);
    w0 = we_cnt;
    do_req(1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'd0); bus.req_valid_i = 1'b0;
    wait_rsp(lat, rd, er);
    chk("wload_lat", 32'(lat), 32'd2);
    chk("wload_rdata", rd, 32'h8BAD_F00D);
    chk("wload_err", {31'd0, er}, 32'd0);
    chk("wload_no_we", 32'(we_cnt - w0), 32'd0);

    // Signed / unsigned byte load
    set_word(4'd0, 32'h80FF_1234);
    do_req(1'b0, 2'd0, 1'b0, 32'h1000_0003, 32'd0); bus.req_valid_i = 1'b0;
    chk("bload_addr", bus.mem_address_o, 32'h1000_0000);
    wait_rsp(lat, rd, er);
    chk("bload_s_rdata", rd, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h1000_0003, 32'd0); bus.req_valid_i = 1'b0;
    wait_rsp(lat, rd, er);
    chk("bload_u_rdata", rd, 32'h0000_0080);

    // Byte store
    set_word(4'd0, 32'h1122_3344);
    w0 = we_cnt;
    do_req(1'b1, 2'd0, 1'b0, 32'h1000_0001, 32'h0000_00AB); bus.req_valid_i = 1'b0;
    wait_rsp(lat, rd, er);
    if (RMW) begin
      chk("bstore_lat", 32'(lat), 32'd3);
      chk("bstore_err", {31'd0, er}, 32'd0);
      chk("bstore_we_cnt", 32'(we_cnt - w0), 32'd1);
      chk("bstore_wdata", last_wd, 32'h1122_AB44);
      chk("bstore_mem", mem[0], 32'h1122_AB44);
    end else begin
      chk("bstore_lat", 32'(lat), 32'd1);
      chk("bstore_err", {31'd0, er}, 32'd1);
      chk("bstore_we_cnt", 32'(we_cnt - w0), 32'd0);
      chk("bstore_mem", mem[0], 32'h1122_3344);
    end

    // ROM store and misaligned halfword load
    w0 = we_cnt;
    do_req(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF); bus.req_valid_i = 1'b0;
    wait_rsp(lat, rd, er);
    chk("rom_lat", 32'(lat), 32'd1);
    chk("rom_err", {31'd0, er}, 32'd1);
    chk("rom_rdata", rd, 32'd0);
    do_req(1'b0, 2'd1, 1'b0, 32'h1000_0001, 32'd0); bus.req_valid_i = 1'b0;
    wait_rsp(lat, rd, er);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_err", {31'd0, er}, 32'd1);
    chk("mis_rdata", rd, 32'd0);
    chk("err_no_we", 32'(we_cnt - w0), 32'd0);

    // ROM boundary
    do_req(1'b1, 2'd2, 1'b0, 32'h0FFF_FFFC, 32'h1234_5678); bus.req_valid_i = 1'b0;
    wait_rsp(lat, rd, er);
    chk("romtop_err", {31'd0, er}, 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'h1000_0000, 32'h1234_5678); bus.req_valid_i = 1'b0;
    wait_rsp(lat, rd, er);
    chk("ramlow_lat", 32'(lat), 32'd2);
    chk("ramlow_err", {31'd0, er}, 32'd0);

    // Reset during WRITE of a word store
    set_word(4'd2, 32'hCAFE_F00D);
    rsp_log.delete();
    do_req(1'b1, 2'd2, 1'b0, 32'h1000_0008, 32'h5555_AAAA); bus.req_valid_i = 1'b0;
    #1 chk("abort_we_before", {31'd0, bus.mem_write_enable_o}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_we_drop", {31'd0, bus.mem_write_enable_o}, 32'd0);
    chk("abort_ready", {31'd0, bus.req_ready_o}, 32'd1);
    chk("abort_no_rsp", {31'd0, bus.rsp_valid_o}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("abort_rsp_count", 32'(rsp_log.size()), 32'd0);

    // Back-to-back word loads with valid held
    set_word(4'd3, 32'h0303_0303);
    set_word(4'd4, 32'h0404_0404);
    set_word(4'd5, 32'h0505_0505);
    rsp_log.delete();
    do_req(1'b0, 2'd2, 1'b0, 32'h1000_000C, 32'd0); t1 = $time;
    do_req(1'b0, 2'd2, 1'b0, 32'h1000_0010, 32'd0); t2 = $time;
    do_req(1'b0, 2'd2, 1'b0, 32'h1000_0014, 32'd0); t3 = $time;
    bus.req_valid_i = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("b2b_gap1", 32'(t2 - t1), 32'd30);
    chk("b2b_gap2", 32'(t3 - t2), 32'd30);
    chk("b2b_count", 32'(rsp_log.size()), 32'd3);
    if (rsp_log.size() == 3) begin
      chk("b2b_rsp0", rsp_log[0], 32'h0303_0303);
      chk("b2b_rsp1", rsp_log[1], 32'h0404_0404);
      chk("b2b_rsp2", rsp_log[2], 32'h0505_0505);
    end

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      logic        w, u;
      logic [1:0]  sz;
      logic [31:0] a;
      w  = 1'($urandom);
      u  = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0FFF_FFFF) : ($urandom | ROM_LIMIT);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_req(w, sz, u, a, $urandom);
      if ($urandom_range(0, 1) == 0) begin
        bus.req_valid_i = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    end
    bus.req_valid_i = 1'b0;
    repeat (6) @(posedge clk); #1;

    for (int i = 0; i < 16; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
